// File: rtl/i2c_scl_generator.sv
// I2C SCL timing generator: programmable period, idle release, mid-low/mid-high/fall strobes.
// Optional slave clock-stretching is compiled in when I2C_CLK_STRETCH_EN is defined.
module i2c_scl_generator #(
  parameter int unsigned CNT_W          = 21,
  parameter int unsigned DEFAULT_PERIOD = 1000,
  parameter int unsigned MIN_PERIOD     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] period_in,
  input  logic             scl_in,
  output logic             scl,
  output logic             cl_low,
  output logic             cl_high,
  output logic             cl_fall,
  output logic             stretched,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, per, per_nxt;
  logic [CNT_W-1:0] half, quarter, last_cnt, rise_cnt, low_pt, high_pt, period_req;
  logic             scl_nxt, stretch_nxt, cl_low_nxt, cl_high_nxt, cl_fall_nxt;
  logic             hold_req, scl_sync;

  assign half       = per >> 1;
  assign quarter    = per >> 2;
  assign last_cnt   = per - ONE;
  assign rise_cnt   = half - ONE;
  assign low_pt     = half - quarter;
  assign high_pt    = half + quarter;
  assign period_req = (period_in < MIN_P) ? MIN_P : period_in;

`ifdef I2C_CLK_STRETCH_EN
  logic scl_meta, scl_sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      scl_meta   <= 1'b1;
      scl_sync_q <= 1'b1;
    end else begin
      scl_meta   <= scl_in;
      scl_sync_q <= scl_meta;
    end
  end

  // Checked two cycles after the rise so the synchroniser has seen our own release.
  assign scl_sync = scl_sync_q;
  assign hold_req = (cnt == half + CNT_W'(2)) && !scl_sync_q;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign scl_sync      = 1'b1;
  assign hold_req      = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    per_nxt     = per;
    scl_nxt     = scl;
    stretch_nxt = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      per_nxt   = period_req;
      scl_nxt   = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          scl_nxt   = 1'b0;
        end
        S_RUN: begin
          if (cnt == last_cnt) begin
            cnt_nxt = '0;
            per_nxt = period_req;
            scl_nxt = 1'b0;
          end else if (hold_req) begin
            state_nxt   = S_HOLD;
            stretch_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + ONE;
            if (cnt == rise_cnt) scl_nxt = 1'b1;
          end
        end
        S_HOLD: begin
          if (scl_sync) begin
            state_nxt = S_RUN;
            cnt_nxt   = cnt + ONE;
          end else begin
            stretch_nxt = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    // Strobes are keyed on the upcoming count so they line up with the registered cnt.
    cl_fall_nxt = enable && (cnt_nxt == '0);
    cl_low_nxt  = enable && (cnt_nxt == low_pt);
    cl_high_nxt = enable && (cnt_nxt == high_pt);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      per       <= CNT_W'(DEFAULT_PERIOD);
      scl       <= 1'b0;
      cl_low    <= 1'b0;
      cl_high   <= 1'b0;
      cl_fall   <= 1'b0;
      stretched <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      per       <= per_nxt;
      scl       <= scl_nxt;
      cl_low    <= cl_low_nxt;
      cl_high   <= cl_high_nxt;
      cl_fall   <= cl_fall_nxt;
      stretched <= stretch_nxt;
      busy      <= enable;
    end
  end

endmodule

// File: tb/tb_i2c_scl_generator.sv
// Self-checking bench for i2c_scl_generator: per-cycle waveform compared to an arithmetic period model.
module tb_i2c_scl_generator;
  localparam int unsigned CNT_W = 21;
`ifdef I2C_CLK_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif
  localparam logic [5:0] IDLE_EXP  = 6'b100000;
  localparam logic [5:0] RESET_EXP = 6'b000000;

  logic             clock = 1'b0;
  logic             reset, enable, scl_in, slave_pull;
  logic [CNT_W-1:0] period_in;
  logic             scl, cl_low, cl_high, cl_fall, stretched, busy;
  logic [5:0]       obs;
  int unsigned      n_checks = 0;
  int unsigned      n_fail = 0;
  int unsigned      cur_p;

  i2c_scl_generator #(.CNT_W(CNT_W), .DEFAULT_PERIOD(1000), .MIN_PERIOD(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .period_in(period_in), .scl_in(scl_in),
    .scl(scl), .cl_low(cl_low), .cl_high(cl_high), .cl_fall(cl_fall),
    .stretched(stretched), .busy(busy)
  );

  always #5 clock = ~clock;

  // Wired-AND bus: a slave can only pull the line low.
  assign scl_in = scl & ~slave_pull;
  assign obs    = {scl, cl_low, cl_high, cl_fall, stretched, busy};

  function automatic int unsigned clamp_p(int unsigned r);
    return (r < 16) ? 16 : r;
  endfunction

  // Expected {scl, cl_low, cl_high, cl_fall, stretched, busy} at position k of a period p.
  function automatic logic [5:0] exp_at(int unsigned p, int unsigned k);
    int unsigned h, q;
    h = p / 2;
    q = p / 4;
    return {k >= h, k == h - q, k == h + q, k == 0, 1'b0, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    enable     = 1'($urandom_range(0, 1));
    period_in  = CNT_W'($urandom_range(0, 2000));
    slave_pull = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs !== RESET_EXP) begin
        n_fail++;
        $display("FAIL reset i=%0d got=%b exp=%b", i, obs, RESET_EXP);
      end
    end
    reset     = 1'b0;
    enable    = 1'b1;
    period_in = CNT_W'(1000);
    cur_p     = 1000;
  endtask

  task automatic test_default_period();
    logic [5:0] e;
    for (int rep = 0; rep < 2; rep++) begin
      for (int unsigned i = 0; i < cur_p; i++) begin
        tick();
        e = exp_at(cur_p, i);
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          if (n_fail <= 30) $display("FAIL default_period rep=%0d i=%0d got=%b exp=%b", rep, i, obs, e);
        end
      end
    end
    cur_p = clamp_p(period_in);
  endtask

  task automatic test_period_change();
    int unsigned reqs[9];
    int unsigned chg;
    logic [5:0]  e;
    reqs = '{100, 5, 5, 101, 101, 0, 0, 0, 1000};
    for (int s = 5; s < 8; s++) reqs[s] = $urandom_range(1, 120);
    for (int s = 0; s < 9; s++) begin
      chg = (s == 0) ? 300 : $urandom_range(0, cur_p - 1);
      for (int unsigned i = 0; i < cur_p; i++) begin
        tick();
        e = exp_at(cur_p, i);
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          if (n_fail <= 30) $display("FAIL period_change seg=%0d p=%0d i=%0d got=%b exp=%b", s, cur_p, i, obs, e);
        end
        if (i == chg) period_in = CNT_W'(reqs[s]);
      end
      cur_p = clamp_p(reqs[s]);
    end
  endtask

  task automatic test_disable();
    int unsigned drop_at, req, idle_n;
    logic [5:0]  e;
    for (int n = 0; n < 4; n++) begin
      drop_at = (n == 0) ? 600 : $urandom_range(0, cur_p - 1);
      for (int unsigned i = 0; i <= drop_at; i++) begin
        tick();
        e = exp_at(cur_p, i);
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          if (n_fail <= 30) $display("FAIL disable_run n=%0d i=%0d got=%b exp=%b", n, i, obs, e);
        end
      end
      enable    = 1'b0;
      req       = (n == 3) ? 1000 : $urandom_range(1, 200);
      period_in = CNT_W'(req);
      idle_n    = $urandom_range(1, 10);
      for (int unsigned j = 0; j < idle_n; j++) begin
        tick();
        n_checks++;
        if (obs !== IDLE_EXP) begin
          n_fail++;
          if (n_fail <= 30) $display("FAIL disable_idle n=%0d j=%0d got=%b exp=%b", n, j, obs, IDLE_EXP);
        end
      end
      enable = 1'b1;
      cur_p  = clamp_p(req);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned r;
    logic [5:0]  e;
    r = $urandom_range(1, cur_p - 1);
    for (int unsigned i = 0; i <= r; i++) begin
      tick();
      e = exp_at(cur_p, i);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        if (n_fail <= 30) $display("FAIL reset_mid_run i=%0d got=%b exp=%b", i, obs, e);
      end
    end
    reset     = 1'b1;
    period_in = CNT_W'(200);
    for (int j = 0; j < 2; j++) begin
      tick();
      n_checks++;
      if (obs !== RESET_EXP) begin
        n_fail++;
        $display("FAIL reset_mid_hold j=%0d got=%b exp=%b", j, obs, RESET_EXP);
      end
    end
    reset = 1'b0;
    cur_p = 1000;
    for (int unsigned i = 0; i < cur_p; i++) begin
      tick();
      e = exp_at(cur_p, i);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        if (n_fail <= 30) $display("FAIL reset_mid_after i=%0d got=%b exp=%b", i, obs, e);
      end
      if (i == 500) period_in = CNT_W'(1000);
    end
    cur_p = 1000;
  endtask

  task automatic test_stretch();
    int unsigned p, h, d, len, last;
    bit          ab;
    logic [5:0]  e;
    for (int it = 0; it < 5; it++) begin
      p    = cur_p;
      h    = p / 2;
      ab   = (it == 4);
      len  = (it == 0) ? 40 : (ab ? 0 : $urandom_range(1, 100));
      d    = STRETCH ? (ab ? 5000 : len) : 0;
      last = ab ? h + 20 : p + d - 1;
      for (int unsigned i = 0; i <= last; i++) begin
        tick();
        if (i <= h + 2)          e = exp_at(p, i);
        else if (i <= h + 2 + d) e = exp_at(p, h + 2) | 6'b000010;
        else                     e = exp_at(p, i - d);
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          if (n_fail <= 30) $display("FAIL stretch it=%0d len=%0d i=%0d got=%b exp=%b", it, len, i, obs, e);
        end
        if (i == h - 1) slave_pull = 1'b1;
        if (!ab && i == h + len - 1) slave_pull = 1'b0;
      end
      if (ab) begin
        enable = 1'b0;
        for (int j = 0; j < 5; j++) begin
          tick();
          n_checks++;
          if (obs !== IDLE_EXP) begin
            n_fail++;
            $display("FAIL stretch_abort j=%0d got=%b exp=%b", j, obs, IDLE_EXP);
          end
        end
        slave_pull = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_period_change();
    test_disable();
    test_reset_mid();
    test_stretch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_scl_generator.md
# i2c_scl_generator

Parametrised I2C SCL timing generator: programmable bus period, enable/idle control, phase-marker pulses and optional slave clock-stretching. Sits under the I2C master byte engine. It supplies the SCL drive level plus single-cycle strobes: mid-low (SDA change point), mid-high (SDA sample point) and falling edge. Period is runtime-programmable and changes only on period boundaries, so SCL never glitches.

## Interface
- `CNT_W`, 21: counter and period width in bits.
- `DEFAULT_PERIOD`, 1000: period loaded at reset, in `clock` cycles.
- `MIN_PERIOD`, 16: floor; smaller programmed periods are clamped up to this value.

- `clock` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high; clock `clock`.
- `enable` in 1: 1 = generate SCL; 0 = idle, SCL released high.
- `period_in` in CNT_W: requested period, sampled only at load points.
- `scl_in` in 1: sensed SCL bus level (asynchronous), used only for stretching.
- `scl` out 1: SCL drive level (0 = pull low, 1 = release).
- `cl_low` out 1: one-cycle strobe at the middle of the low phase.
- `cl_high` out 1: one-cycle strobe at the middle of the high phase.
- `cl_fall` out 1: one-cycle strobe in the first cycle SCL is low.
- `stretched` out 1: high while the counter is held by a stretching slave.
- `busy` out 1: high while enabled and generating.

## Operation
- Registers: `cnt` (CNT_W), `per` (active period), `scl`, the strobes, and a 2-flop `scl_in` synchroniser.
- `P` = `per`, `H` = `P>>1`, `Q` = `P>>2`. All values come from the latched `per`, never from `period_in` directly.
- Load points are reset, `enable`=0, and `cnt`==P-1. At each load point, `per` <= max(`period_in`, MIN_PERIOD). At reset, `per` <= DEFAULT_PERIOD instead.
- `cnt` counts 0..P-1, then wraps to 0. It is held at 0 while `enable`=0.
- SCL level by count:
  - Low for `cnt` 0..H-1.
  - High for `cnt` H..P-1.
  - `scl` is registered: it is set when `cnt`==H-1 and cleared when `cnt`==P-1.
- Strobes (registered):
  - `cl_low`=1 in the cycle `cnt`==H-Q.
  - `cl_high`=1 in the cycle `cnt`==H+Q.
  - `cl_fall`=1 in the cycle `cnt`==0 while enabled.
- Odd periods: the high phase gets the extra cycle. P=101 gives 50 low and 51 high.
- Disable: `enable`=0 forces `scl`=1, `cnt`=0, all strobes 0 and `busy`=0 on the next edge, from any count.
- Re-enable: the first enabled cycle has `cnt`=0 with `scl`=0 and `cl_fall`=1.
- `reset` has priority over everything, including mid-period.

## Timing
- Reset values:
  - `scl`=0 (matches the legacy generator).
  - `cl_low`, `cl_high`, `cl_fall`, `stretched`, `busy` = 0.
  - `cnt`=0, `per`=DEFAULT_PERIOD.
- Latency: every output is registered, one cycle after the count condition.
- A `period_in` change takes effect at the next wrap. The current period always completes unchanged.
- Stretch check point is `cnt`==H+2. This allows for the 2-cycle synchroniser latency after the `scl` rise; MIN_PERIOD ≥ 16 guarantees H+2 < H+Q.

## Configuration
- `I2C_CLK_STRETCH_EN` defined:
  - At `cnt`==H+2, if synchronised `scl_in`=0, `cnt` holds and `stretched`=1 until synced `scl_in`=1.
  - The next cycle resumes counting with `stretched`=0.
  - `cl_high` and the fall are delayed by the hold length; the high-phase length after release is unchanged.
  - `enable`=0 or `reset` aborts the hold.
- `I2C_CLK_STRETCH_EN` undefined: `scl_in` and the synchroniser are unused, `stretched` is tied 0, and the count never holds.

## Test plan
- Reset, then `enable`=1, default period:
  - `scl` low for counts 0..499 and high for 500..999, repeating.
  - `cl_low` at count 250, `cl_high` at 750, `cl_fall` at 0.
  - All outputs 0 during reset.
- Write `period_in`=100 at count 300 → the current 1000-cycle period completes. Then `scl` high 50..99, `cl_low` at 25, `cl_high` at 75.
- `period_in`=5 → clamped to 16: `scl` low 8 cycles, high 8 cycles, `cl_low` at 4, `cl_high` at 12.
- `period_in`=101 → 50 cycles low, 51 high, `cl_high` at 75.
- Drop `enable` at count 600 → next cycle `scl`=1, `busy`=0, no strobes. Re-enable → `cl_fall` immediately, full low phase follows. Assert `reset` mid-period → `scl`=0, `cnt`=0.
- With `I2C_CLK_STRETCH_EN`, P=1000:
  - Hold `scl_in` low for 40 cycles after the `scl` rise → `stretched`=1 and `cnt` frozen at 502. `cl_high` arrives correspondingly late; high phase after release is still 500 cycles.
  - Without the macro, the same stimulus leaves the waveform unchanged.
